// File: rtl/converta_env_pkg.sv
// Shared types and constants for the converta closed-loop environment.
package converta_env_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_DLY_UP,
    P_WAIT_UP,
    P_DLY_DN,
    P_WAIT_DN
  } p_state_t;

  typedef enum logic [1:0] {
    C_WAIT_UP,
    C_DLY_UP,
    C_WAIT_DN,
    C_DLY_DN
  } c_state_t;

  // Positions of the sticky error flags in err.
  localparam int ERR_AO    = 0;
  localparam int ERR_RO    = 1;
  localparam int ERR_INST  = 2;
  localparam int ERR_MULTI = 3;

endpackage

// File: rtl/converta_env_dly.sv
// Loadable down-counter. fire is high for the single cycle in which an
// armed countdown reaches zero, so a load of N fires N+1 cycles later.
module converta_env_dly #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         fire
);

  logic [W-1:0] cnt;
  logic         run;

  // Capture the delay at load, then count down once per cycle until zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign fire = run && (cnt == '0);

endmodule

// File: rtl/converta_env.sv
// Far end of both converta handshakes: produces Ri events and answers Ao
// on the input side, consumes Ro events and answers with Ai on the output
// side, counting completed handshakes and latching protocol errors.
//
// state     | meaning
// P_IDLE    | producer parked, waiting for enable
// P_DLY_UP  | counting down before Ri_PLUS
// P_WAIT_UP | Ri_PLUS issued, waiting for Ao_PLUS
// P_DLY_DN  | counting down before Ri_MINUS
// P_WAIT_DN | Ri_MINUS issued, waiting for Ao_MINUS
// C_WAIT_UP | consumer waiting for Ro_PLUS / Ro_PLUSa
// C_DLY_UP  | counting down before Ai_PLUS(a)
// C_WAIT_DN | waiting for Ro_MINUS / Ro_MINUSa
// C_DLY_DN  | counting down before Ai_MINUS(a)
module converta_env
  import converta_env_pkg::*;
#(
  parameter int DLY_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DLY_W-1:0] ri_dly,
  input  logic [DLY_W-1:0] ai_dly,
  input  logic             Ao_PLUS,
  input  logic             Ao_MINUS,
  input  logic             Ro_PLUS,
  input  logic             Ro_PLUSa,
  input  logic             Ro_MINUS,
  input  logic             Ro_MINUSa,
  output logic             Ri_PLUS,
  output logic             Ri_MINUS,
  output logic             Ai_PLUS,
  output logic             Ai_PLUSa,
  output logic             Ai_MINUS,
  output logic             Ai_MINUSa,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt,
  output logic [3:0]       err
);

  p_state_t p_state, p_nxt;
  c_state_t c_state, c_nxt;
  logic     inst, inst_nxt;
  logic     p_load, p_fire, c_load, c_fire;
  logic     ri_plus_nxt, ri_minus_nxt, in_inc;
  logic     ai_plus_nxt, ai_plusa_nxt, ai_minus_nxt, ai_minusa_nxt, out_inc;
  logic     err_ro, err_inst;
  logic [3:0] err_set;

  // Simultaneous events on one side are rejected as a whole.
  logic ao_multi, ao_plus_v, ao_minus_v;
  logic ro_multi, ro_up, ro_dn;
  assign ao_multi   = Ao_PLUS & Ao_MINUS;
  assign ao_plus_v  = Ao_PLUS & ~Ao_MINUS;
  assign ao_minus_v = Ao_MINUS & ~Ao_PLUS;
  assign ro_multi   = $countones({Ro_PLUS, Ro_PLUSa, Ro_MINUS, Ro_MINUSa}) > 1;
  assign ro_up      = ~ro_multi & (Ro_PLUS | Ro_PLUSa);
  assign ro_dn      = ~ro_multi & (Ro_MINUS | Ro_MINUSa);

  converta_env_dly #(.W(DLY_W)) u_p_dly (
    .clk(clk), .rst_n(reset), .load(p_load), .load_val(ri_dly), .fire(p_fire)
  );

  converta_env_dly #(.W(DLY_W)) u_c_dly (
    .clk(clk), .rst_n(reset), .load(c_load), .load_val(ai_dly), .fire(c_fire)
  );

  // Producer next state and pulse requests.
  always_comb begin
    p_nxt        = p_state;
    p_load       = 1'b0;
    ri_plus_nxt  = 1'b0;
    ri_minus_nxt = 1'b0;
    in_inc       = 1'b0;
    case (p_state)
      P_IDLE:    if (enable) begin p_load = 1'b1; p_nxt = P_DLY_UP; end
      P_DLY_UP:  if (p_fire) begin ri_plus_nxt = 1'b1; p_nxt = P_WAIT_UP; end
      P_WAIT_UP: if (ao_plus_v) begin p_load = 1'b1; p_nxt = P_DLY_DN; end
      P_DLY_DN:  if (p_fire) begin ri_minus_nxt = 1'b1; p_nxt = P_WAIT_DN; end
      P_WAIT_DN: if (ao_minus_v) begin
        in_inc = 1'b1;
        if (enable) begin p_load = 1'b1; p_nxt = P_DLY_UP; end
        else        p_nxt = P_IDLE;
      end
      default:   p_nxt = P_IDLE;
    endcase
  end

  // Consumer next state, instance tracking and pulse requests.
  always_comb begin
    c_nxt         = c_state;
    c_load        = 1'b0;
    inst_nxt      = inst;
    ai_plus_nxt   = 1'b0;
    ai_plusa_nxt  = 1'b0;
    ai_minus_nxt  = 1'b0;
    ai_minusa_nxt = 1'b0;
    out_inc       = 1'b0;
    err_ro        = 1'b0;
    err_inst      = 1'b0;
    case (c_state)
      C_WAIT_UP: begin
        if (ro_up) begin
          inst_nxt = Ro_PLUSa;
          c_load   = 1'b1;
          c_nxt    = C_DLY_UP;
        end else if (ro_dn) err_ro = 1'b1;
      end
      C_DLY_UP: begin
        err_ro = ro_up | ro_dn;
        if (c_fire) begin
          ai_plus_nxt  = ~inst;
          ai_plusa_nxt = inst;
          c_nxt        = C_WAIT_DN;
        end
      end
      C_WAIT_DN: begin
        if (ro_dn) begin
          // A mismatched Ro- is flagged but still answered on its own instance.
          err_inst = (Ro_MINUSa != inst);
          inst_nxt = Ro_MINUSa;
          c_load   = 1'b1;
          c_nxt    = C_DLY_DN;
        end else if (ro_up) err_ro = 1'b1;
      end
      C_DLY_DN: begin
        err_ro = ro_up | ro_dn;
        if (c_fire) begin
          ai_minus_nxt  = ~inst;
          ai_minusa_nxt = inst;
          out_inc       = 1'b1;
          c_nxt         = C_WAIT_UP;
        end
      end
      default: c_nxt = C_WAIT_UP;
    endcase
  end

  // Collect this cycle's error conditions.
  always_comb begin
    err_set            = '0;
    err_set[ERR_AO]    = (ao_plus_v && (p_state != P_WAIT_UP)) ||
                         (ao_minus_v && (p_state != P_WAIT_DN));
    err_set[ERR_RO]    = err_ro;
    err_set[ERR_INST]  = err_inst;
    err_set[ERR_MULTI] = ao_multi | ro_multi;
  end

  // Producer state, Ri pulses and input handshake counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state  <= P_IDLE;
      Ri_PLUS  <= 1'b0;
      Ri_MINUS <= 1'b0;
      in_cnt   <= '0;
    end else begin
      p_state  <= p_nxt;
      Ri_PLUS  <= ri_plus_nxt;
      Ri_MINUS <= ri_minus_nxt;
      if (in_inc) in_cnt <= in_cnt + 1'b1;
    end
  end

  // Consumer state, Ai pulses and output handshake counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_state   <= C_WAIT_UP;
      inst      <= 1'b0;
      Ai_PLUS   <= 1'b0;
      Ai_PLUSa  <= 1'b0;
      Ai_MINUS  <= 1'b0;
      Ai_MINUSa <= 1'b0;
      out_cnt   <= '0;
    end else begin
      c_state   <= c_nxt;
      inst      <= inst_nxt;
      Ai_PLUS   <= ai_plus_nxt;
      Ai_PLUSa  <= ai_plusa_nxt;
      Ai_MINUS  <= ai_minus_nxt;
      Ai_MINUSa <= ai_minusa_nxt;
      if (out_inc) out_cnt <= out_cnt + 1'b1;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= '0;
    else        err <= err | err_set;
  end

endmodule

// File: tb/tb_converta_env.sv
// Directed bench for converta_env: input-side producer loop, output-side
// consumer responses, error flags and reset abort.
module tb_converta_env;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  ri_dly = '0;
  logic [3:0]  ai_dly = '0;
  logic        Ao_PLUS = 1'b0, Ao_MINUS = 1'b0;
  logic        Ro_PLUS = 1'b0, Ro_PLUSa = 1'b0, Ro_MINUS = 1'b0, Ro_MINUSa = 1'b0;
  logic        Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa;
  logic [15:0] in_cnt, out_cnt;
  logic [3:0]  err;

  int checks = 0;
  int failures = 0;

  converta_env #(.DLY_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ri_dly(ri_dly), .ai_dly(ai_dly),
    .Ao_PLUS(Ao_PLUS), .Ao_MINUS(Ao_MINUS),
    .Ro_PLUS(Ro_PLUS), .Ro_PLUSa(Ro_PLUSa), .Ro_MINUS(Ro_MINUS), .Ro_MINUSa(Ro_MINUSa),
    .Ri_PLUS(Ri_PLUS), .Ri_MINUS(Ri_MINUS),
    .Ai_PLUS(Ai_PLUS), .Ai_PLUSa(Ai_PLUSa), .Ai_MINUS(Ai_MINUS), .Ai_MINUSa(Ai_MINUSa),
    .in_cnt(in_cnt), .out_cnt(out_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    {Ao_PLUS, Ao_MINUS, Ro_PLUS, Ro_PLUSa, Ro_MINUS, Ro_MINUSa} = '0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [5:0] ev;
    reset = 1'b0;
    step();
    step();
    ev = {Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa};
    checks++; if (ev !== 6'b0) begin failures++; $display("FAIL reset_events got=%b exp=000000", ev); end
    checks++; if (in_cnt !== 16'd0) begin failures++; $display("FAIL reset_in_cnt got=%0d exp=0", in_cnt); end
    checks++; if (out_cnt !== 16'd0) begin failures++; $display("FAIL reset_out_cnt got=%0d exp=0", out_cnt); end
    checks++; if (err !== 4'b0) begin failures++; $display("FAIL reset_err got=%b exp=0000", err); end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (Ri_PLUS !== 1'b0) begin failures++; $display("FAIL idle_no_ri cyc=%0d got=%b exp=0", k, Ri_PLUS); end
    end
  endtask

  task automatic test_handshakes();
    apply_reset();
    ri_dly = 4'd0;
    enable = 1'b1;
    step();
    checks++; if (Ri_PLUS !== 1'b0) begin failures++; $display("FAIL start_early got=%b exp=0", Ri_PLUS); end
    for (int h = 0; h < 10; h++) begin
      step();
      checks++; if (Ri_PLUS !== 1'b1) begin failures++; $display("FAIL hs_ri_plus h=%0d got=%b exp=1", h, Ri_PLUS); end
      Ao_PLUS = 1'b1; step(); Ao_PLUS = 1'b0;
      checks++; if (Ri_MINUS !== 1'b0) begin failures++; $display("FAIL hs_ri_minus_early h=%0d got=%b exp=0", h, Ri_MINUS); end
      step();
      checks++; if (Ri_MINUS !== 1'b1) begin failures++; $display("FAIL hs_ri_minus h=%0d got=%b exp=1", h, Ri_MINUS); end
      if (h == 9) enable = 1'b0;
      Ao_MINUS = 1'b1; step(); Ao_MINUS = 1'b0;
      checks++; if (in_cnt !== 16'(h + 1)) begin failures++; $display("FAIL hs_in_cnt h=%0d got=%0d exp=%0d", h, in_cnt, h + 1); end
    end
    checks++; if (err !== 4'b0) begin failures++; $display("FAIL hs_err got=%b exp=0000", err); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (Ri_PLUS !== 1'b0) begin failures++; $display("FAIL hs_parked cyc=%0d got=%b exp=0", k, Ri_PLUS); end
    end
  endtask

  task automatic test_consumer_a();
    logic exp;
    apply_reset();
    ai_dly = 4'd3;
    Ro_PLUSa = 1'b1; step(); Ro_PLUSa = 1'b0;
    ai_dly = 4'd15;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp = (k == 4);
      checks++; if (Ai_PLUSa !== exp) begin failures++; $display("FAIL ai_plusa k=%0d got=%b exp=%b", k, Ai_PLUSa, exp); end
      checks++; if (Ai_PLUS !== 1'b0) begin failures++; $display("FAIL ai_plus_quiet k=%0d got=%b exp=0", k, Ai_PLUS); end
    end
    ai_dly = 4'd3;
    Ro_MINUSa = 1'b1; step(); Ro_MINUSa = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp = (k == 4);
      checks++; if (Ai_MINUSa !== exp) begin failures++; $display("FAIL ai_minusa k=%0d got=%b exp=%b", k, Ai_MINUSa, exp); end
      checks++; if (out_cnt !== ((k >= 4) ? 16'd1 : 16'd0)) begin failures++; $display("FAIL a_out_cnt k=%0d got=%0d exp=%0d", k, out_cnt, (k >= 4) ? 1 : 0); end
    end
    checks++; if (err !== 4'b0) begin failures++; $display("FAIL a_err got=%b exp=0000", err); end
  endtask

  task automatic test_inst_mismatch();
    apply_reset();
    ai_dly = 4'd0;
    Ro_PLUS = 1'b1; step(); Ro_PLUS = 1'b0;
    step();
    checks++; if (Ai_PLUS !== 1'b1) begin failures++; $display("FAIL mm_ai_plus got=%b exp=1", Ai_PLUS); end
    Ro_MINUSa = 1'b1; step(); Ro_MINUSa = 1'b0;
    step();
    checks++; if ({Ai_MINUS, Ai_MINUSa} !== 2'b01) begin failures++; $display("FAIL mm_ai_minus got=%b exp=01", {Ai_MINUS, Ai_MINUSa}); end
    checks++; if (out_cnt !== 16'd1) begin failures++; $display("FAIL mm_out_cnt got=%0d exp=1", out_cnt); end
    checks++; if (err !== 4'b0100) begin failures++; $display("FAIL mm_err got=%b exp=0100", err); end
  endtask

  task automatic test_ro_polarity();
    apply_reset();
    ai_dly = 4'd0;
    Ro_MINUS = 1'b1; step(); Ro_MINUS = 1'b0;
    checks++; if (err !== 4'b0010) begin failures++; $display("FAIL pol_err got=%b exp=0010", err); end
    step();
    checks++; if ({Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa} !== 4'b0) begin failures++; $display("FAIL pol_no_ai got=%b exp=0000", {Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa}); end
    Ro_PLUS = 1'b1; step(); Ro_PLUS = 1'b0;
    step();
    checks++; if (Ai_PLUS !== 1'b1) begin failures++; $display("FAIL pol_recover got=%b exp=1", Ai_PLUS); end
  endtask

  task automatic test_multi_ao();
    apply_reset();
    ri_dly = 4'd0;
    enable = 1'b1;
    step();
    step();
    checks++; if (Ri_PLUS !== 1'b1) begin failures++; $display("FAIL multi_ri_plus got=%b exp=1", Ri_PLUS); end
    Ao_PLUS = 1'b1; Ao_MINUS = 1'b1; step(); Ao_PLUS = 1'b0; Ao_MINUS = 1'b0;
    checks++; if (err[3] !== 1'b1) begin failures++; $display("FAIL multi_err3 got=%b exp=1", err[3]); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (Ri_MINUS !== 1'b0) begin failures++; $display("FAIL multi_no_ri_minus cyc=%0d got=%b exp=0", k, Ri_MINUS); end
    end
    Ao_PLUS = 1'b1; step(); Ao_PLUS = 1'b0;
    step();
    checks++; if (Ri_MINUS !== 1'b1) begin failures++; $display("FAIL multi_still_wait_up got=%b exp=1", Ri_MINUS); end
    enable = 1'b0;
    Ao_MINUS = 1'b1; step(); Ao_MINUS = 1'b0;
    checks++; if (in_cnt !== 16'd1) begin failures++; $display("FAIL multi_in_cnt got=%0d exp=1", in_cnt); end
  endtask

  task automatic test_enable_drop();
    logic exp;
    apply_reset();
    ri_dly = 4'd2;
    enable = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = (k == 3);
      checks++; if (Ri_PLUS !== exp) begin failures++; $display("FAIL drop_start k=%0d got=%b exp=%b", k, Ri_PLUS, exp); end
    end
    enable = 1'b0;
    Ao_PLUS = 1'b1; step(); Ao_PLUS = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = (k == 3);
      checks++; if (Ri_MINUS !== exp) begin failures++; $display("FAIL drop_ri_minus k=%0d got=%b exp=%b", k, Ri_MINUS, exp); end
    end
    Ao_MINUS = 1'b1; step(); Ao_MINUS = 1'b0;
    checks++; if (in_cnt !== 16'd1) begin failures++; $display("FAIL drop_in_cnt got=%0d exp=1", in_cnt); end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (Ri_PLUS !== 1'b0) begin failures++; $display("FAIL drop_no_restart cyc=%0d got=%b exp=0", k, Ri_PLUS); end
    end
    checks++; if (in_cnt !== 16'd1) begin failures++; $display("FAIL drop_in_cnt_final got=%0d exp=1", in_cnt); end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    ai_dly = 4'd0;
    Ro_PLUS = 1'b1; step(); Ro_PLUS = 1'b0;
    step();
    Ro_MINUS = 1'b1; step(); Ro_MINUS = 1'b0;
    step();
    checks++; if (out_cnt !== 16'd1) begin failures++; $display("FAIL abort_pre_cnt got=%0d exp=1", out_cnt); end
    ai_dly = 4'd7;
    Ro_PLUS = 1'b1; step(); Ro_PLUS = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    #1;
    checks++; if ({Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa} !== 6'b0) begin failures++; $display("FAIL abort_events got=%b exp=000000", {Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa}); end
    checks++; if (out_cnt !== 16'd0) begin failures++; $display("FAIL abort_out_cnt got=%0d exp=0", out_cnt); end
    step();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if ({Ai_PLUS, Ai_PLUSa} !== 2'b00) begin failures++; $display("FAIL abort_no_ai cyc=%0d got=%b exp=00", k, {Ai_PLUS, Ai_PLUSa}); end
    end
    checks++; if (out_cnt !== 16'd0) begin failures++; $display("FAIL abort_out_cnt_after got=%0d exp=0", out_cnt); end
    checks++; if (in_cnt !== 16'd0) begin failures++; $display("FAIL abort_in_cnt_after got=%0d exp=0", in_cnt); end
    checks++; if (err !== 4'b0) begin failures++; $display("FAIL abort_err got=%b exp=0000", err); end
  endtask

  initial begin
    test_reset();
    test_handshakes();
    test_consumer_a();
    test_inst_mismatch();
    test_ro_polarity();
    test_multi_ao();
    test_enable_drop();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/converta_env.md
# converta_env

Synthesisable environment for the converta Mealy multi-FSM controller: the far end of both of its handshakes. It produces the input-side request events (Ri+/Ri-) and answers the controller's Ao events, and it consumes output-side requests (Ro+/Ro-, plain and "a" instances) and answers them with the matching Ai events after a programmable delay. It is used for closed-loop simulation and on-chip self-test of the controller. It counts completed handshakes and flags protocol violations.

## Interface
- DLY_W, 4, width of the per-side response-delay operands
- CNT_W, 16, width of the handshake counters
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  allows the producer to start new input handshakes
- ri_dly  in  DLY_W  idle cycles inserted before each Ri event
- ai_dly  in  DLY_W  idle cycles inserted before each Ai event
- Ao_PLUS, Ao_MINUS  in  1 each  controller input-side acknowledge events, one-cycle pulses
- Ro_PLUS, Ro_PLUSa, Ro_MINUS, Ro_MINUSa  in  1 each  controller output-side request events, one-cycle pulses
- Ri_PLUS, Ri_MINUS  out  1 each  request events to the controller, registered one-cycle pulses
- Ai_PLUS, Ai_PLUSa, Ai_MINUS, Ai_MINUSa  out  1 each  acknowledge events to the controller, registered one-cycle pulses
- in_cnt  out  CNT_W  completed input handshakes
- out_cnt  out  CNT_W  completed output handshakes
- err  out  4  sticky error flags

## Operation
- Producer FSM, states P_IDLE, P_DLY_UP, P_WAIT_UP, P_DLY_DN, P_WAIT_DN:
  - P_IDLE: when enable=1, load ri_dly and go to P_DLY_UP.
  - P_DLY_UP: at count 0, pulse Ri_PLUS and go to P_WAIT_UP.
  - P_WAIT_UP: on Ao_PLUS, load ri_dly and go to P_DLY_DN.
  - P_DLY_DN: at count 0, pulse Ri_MINUS and go to P_WAIT_DN.
  - P_WAIT_DN: on Ao_MINUS, in_cnt++; go to P_DLY_UP (reload ri_dly) if enable=1, else to P_IDLE.
- Consumer FSM, states C_WAIT_UP, C_DLY_UP, C_WAIT_DN, C_DLY_DN, plus an instance bit inst:
  - C_WAIT_UP: Ro_PLUS sets inst=0; Ro_PLUSa sets inst=1. Either one loads ai_dly and moves to C_DLY_UP.
  - C_DLY_UP: at count 0, pulse Ai_PLUS (inst=0) or Ai_PLUSa (inst=1), then go to C_WAIT_DN.
  - C_WAIT_DN: Ro_MINUS or Ro_MINUSa loads ai_dly, moves to C_DLY_DN and records the instance.
  - C_DLY_DN: at count 0, pulse Ai_MINUS or Ai_MINUSa according to the recorded instance, out_cnt++, then go to C_WAIT_UP.
- err bits:
  - [0] Ao event outside P_WAIT_UP/P_WAIT_DN, or of the wrong polarity.
  - [1] Ro event outside C_WAIT_UP/C_WAIT_DN, or of the wrong polarity.
  - [2] Ro- instance differs from the inst latched at Ro+. The response still follows the Ro- instance.
  - [3] two or more events on the same side in one cycle.
- Offending events are otherwise ignored and cause no state change. Under err[3], no event of that cycle is accepted.
- err bits are sticky until reset.
- Counters wrap modulo 2^CNT_W.
- enable deasserted mid-handshake: the current handshake completes through Ri_MINUS and Ao_MINUS, then the producer goes to P_IDLE. The consumer ignores enable.

## Timing
- Reset values: all event outputs 0, in_cnt=0, out_cnt=0, err=0, producer in P_IDLE, consumer in C_WAIT_UP, inst=0.
- Asserting reset mid-operation aborts immediately and any pending pulse is dropped.
- Input events are sampled on the rising clk edge. Each output pulse is high for exactly one cycle.
- Response latency: an event sampled at edge t produces its answer pulse high in cycle t+1+dly (dly=0 gives the next cycle).
- Start latency: enable sampled high in P_IDLE at edge t gives Ri_PLUS in cycle t+1+ri_dly.
- The delay operand is captured at load. Later changes to it do not affect a countdown already in progress.
- Counter updates coincide with the issue of the closing pulse (out_cnt) or with sampling of Ao_MINUS (in_cnt).

## Structure
- converta_env_pkg holds:
  - producer and consumer state enums;
  - err bit index constants ERR_AO, ERR_RO, ERR_INST, ERR_MULTI.
- One sub-module, converta_env_dly, instantiated twice (producer and consumer). It is a loadable DLY_W down-counter with a one-cycle "fire" strobe.

## Test plan
- enable=1, ri_dly=0, ai_dly=0, bench echoes Ao one cycle after each Ri → Ri_PLUS in cycle 1 after enable; after 10 handshakes in_cnt=10, err=0.
- Ro_PLUSa at edge t with ai_dly=3 → Ai_PLUSa high only in cycle t+4. Ro_MINUSa then gives Ai_MINUSa, out_cnt=1.
- Ro_PLUS followed by Ro_MINUSa → err=4'b0100, Ai_MINUSa issued, out_cnt=1.
- Ao_PLUS and Ao_MINUS in the same cycle during P_WAIT_UP → err[3]=1, producer stays in P_WAIT_UP, no Ri_MINUS.
- Deassert enable between Ri_PLUS and Ao_PLUS → Ri_MINUS is still issued, in_cnt increments once, then no further Ri_PLUS.
- Assert reset (low) during C_DLY_UP with ai_dly=7 → no Ai pulse. After release, all outputs are 0 and counters read 0.
